// File: rtl/tube_ctrl_pkg.sv
// Shared constants for the tube readout controller: FSM state codes, header tag and word width.
package tube_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_CLEAR  = 3'd1;
  localparam state_t S_WINDOW = 3'd2;
  localparam state_t S_SNAP   = 3'd3;
  localparam state_t S_HEADER = 3'd4;
  localparam state_t S_READ   = 3'd5;

  localparam logic [7:0]  HEADER_TAG = 8'hA5;
  localparam int unsigned WORD_W     = 16;
  localparam int unsigned IDX_W      = 8;

endpackage

// File: rtl/tube_snap_buf.sv
// Snapshot registers for all tube counters: capture strobe, indexed read port and per-channel keep mask.
// With TUBE_CTRL_ZERO_SUPPRESS_EN defined, keep_c flags only channels that saw a hit (count < WINDOW).
module tube_snap_buf
  import tube_ctrl_pkg::*;
#(
  parameter int unsigned NUM_TUBES = 16,
`ifdef TUBE_CTRL_ZERO_SUPPRESS_EN
  parameter int unsigned WINDOW    = 200,
`endif
  parameter int unsigned CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       cap,
  input  logic [NUM_TUBES*CNT_W-1:0] tube_data,
  input  logic [IDX_W-1:0]           rd_idx,
  output logic [CNT_W-1:0]           rd_data_c,
  output logic [NUM_TUBES-1:0]       keep_c
);

  logic [CNT_W-1:0] snap_q [NUM_TUBES];
  logic [CNT_W-1:0] snap_d [NUM_TUBES];

  always_comb begin
    for (int i = 0; i < int'(NUM_TUBES); i++) begin
      snap_d[i] = cap ? tube_data[i*CNT_W +: CNT_W] : snap_q[i];
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < int'(NUM_TUBES); i++) snap_q[i] <= '0;
    end else begin
      snap_q <= snap_d;
    end
  end

  always_comb begin
    rd_data_c = '0;
    for (int i = 0; i < int'(NUM_TUBES); i++) begin
      if (rd_idx == IDX_W'(i)) rd_data_c = snap_q[i];
    end
  end

  // Keep mask looks at snap_d so the header can decide out_last in the capture cycle itself.
`ifdef TUBE_CTRL_ZERO_SUPPRESS_EN
  always_comb begin
    for (int i = 0; i < int'(NUM_TUBES); i++) begin
      keep_c[i] = 32'(snap_d[i]) < WINDOW;
    end
  end
`else
  assign keep_c = '1;
`endif

endmodule

// File: rtl/tube_readout_ctrl.sv
// Tube readout sequencer: clear, gate window, snapshot, then stream header plus one word per channel.
// Optional macro TUBE_CTRL_ZERO_SUPPRESS_EN skips channels without a hit during readout.
module tube_readout_ctrl
  import tube_ctrl_pkg::*;
#(
  parameter int unsigned NUM_TUBES  = 16,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned CLR_CYCLES = 2,
  parameter int unsigned WINDOW     = 200
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       trigger,
  input  logic [NUM_TUBES*CNT_W-1:0] tube_data,
  output logic                       tube_clr,
  output logic                       gate_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORD_W-1:0]          out_data,
  output logic                       out_last,
  output logic                       busy,
  output logic [7:0]                 drop_cnt
);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        event_q, event_d;
  logic [7:0]        drop_q, drop_d;
  logic              tube_clr_q, tube_clr_d;
  logic              gate_en_q, gate_en_d;
  logic              busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;

  logic                 cap_c;
  logic                 xfer_c;
  logic [NUM_TUBES-1:0] keep_c;
  logic [CNT_W-1:0]     rd_data_c;
  logic [IDX_W-1:0]     nxt_idx_c;
  logic                 nxt_found_c;
  logic                 nxt_more_c;

  tube_snap_buf #(
    .NUM_TUBES(NUM_TUBES),
`ifdef TUBE_CTRL_ZERO_SUPPRESS_EN
    .WINDOW   (WINDOW),
`endif
    .CNT_W    (CNT_W)
  ) u_snap (
    .clk      (clk),
    .clr      (clr),
    .cap      (cap_c),
    .tube_data(tube_data),
    .rd_idx   (nxt_idx_c),
    .rd_data_c(rd_data_c),
    .keep_c   (keep_c)
  );

  // Lowest kept channel after the current one (from 0 in HEADER), and whether any kept one follows it.
  always_comb begin
    nxt_found_c = 1'b0;
    nxt_more_c  = 1'b0;
    nxt_idx_c   = '0;
    for (int i = int'(NUM_TUBES) - 1; i >= 0; i--) begin
      if (keep_c[i] && (state_q == S_HEADER || i > int'(idx_q))) begin
        nxt_more_c  = nxt_more_c | nxt_found_c;
        nxt_found_c = 1'b1;
        nxt_idx_c   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    event_d     = event_q;
    drop_d      = drop_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    cap_c       = 1'b0;
    xfer_c      = out_valid_q && out_ready;

    if (trigger && state_q != S_IDLE && drop_q != 8'hFF) drop_d = drop_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          event_d = event_q + 8'd1;
        end
      end
      S_CLEAR: begin
        if (cnt_q == 8'(CLR_CYCLES - 1)) begin
          state_d = S_WINDOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WINDOW: begin
        if (cnt_q == 8'(WINDOW - 1)) begin
          state_d = S_SNAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SNAP: begin
        cap_c       = 1'b1;
        state_d     = S_HEADER;
        out_valid_d = 1'b1;
        out_data_d  = {HEADER_TAG, event_q};
        out_last_d  = ~|keep_c;
      end
      S_HEADER, S_READ: begin
        if (xfer_c) begin
          if (out_last_q || !nxt_found_c) begin
            state_d     = S_IDLE;
            idx_d       = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
          end else begin
            state_d    = S_READ;
            idx_d      = nxt_idx_c;
            out_data_d = {nxt_idx_c, 8'(rd_data_c)};
            out_last_d = ~nxt_more_c;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    tube_clr_d = (state_d == S_IDLE) || (state_d == S_CLEAR);
    gate_en_d  = (state_d == S_WINDOW);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      event_q     <= '0;
      drop_q      <= '0;
      tube_clr_q  <= 1'b1;
      gate_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      event_q     <= event_d;
      drop_q      <= drop_d;
      tube_clr_q  <= tube_clr_d;
      gate_en_q   <= gate_en_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign tube_clr  = tube_clr_q;
  assign gate_en   = gate_en_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_tube_readout_ctrl.sv
// Self-checking bench for tube_readout_ctrl with a queue-based readout model.
module tb_tube_readout_ctrl;

  localparam int NT  = 4;
  localparam int CW  = 8;
  localparam int CC  = 2;
  localparam int WIN = 200;
`ifdef TUBE_CTRL_ZERO_SUPPRESS_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            clr;
  logic            trigger;
  logic [NT*CW-1:0] tube_data;
  logic            tube_clr, gate_en, out_valid, out_ready, out_last, busy;
  logic [15:0]     out_data;
  logic [7:0]      drop_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [16:0] got_q[$];
  logic [16:0] exp_q[$];
  logic [7:0]  ev_model = 8'd0;
  int          stab_err = 0;
  logic        prev_stall = 1'b0;
  logic [16:0] prev_word = '0;

  always #5 clk = ~clk;

  tube_readout_ctrl #(
    .NUM_TUBES (NT),
    .CNT_W     (CW),
    .CLR_CYCLES(CC),
    .WINDOW    (WIN)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .trigger  (trigger),
    .tube_data(tube_data),
    .tube_clr (tube_clr),
    .gate_en  (gate_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  // Transfer collector and stall-stability tracker, sampled mid-cycle.
  always @(negedge clk) begin
    if (clr !== 1'b0) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid === 1'b1 && {out_last, out_data} !== prev_word) stab_err++;
      if (out_valid === 1'b1 && out_ready === 1'b1) got_q.push_back({out_last, out_data});
      prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
      prev_word  = {out_last, out_data};
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr;
    clr = 1'b1;
    tick;
    clr = 1'b0;
    ev_model = 8'd0;
  endtask

  // Expected stream: header, then every kept channel in ascending order, last flag on the final word.
  task automatic build_exp(input logic [NT*CW-1:0] vals, input logic [7:0] ev);
    int kept[$];
    exp_q.delete();
    for (int c = 0; c < NT; c++) begin
      if (!ZS || int'(vals[c*CW +: CW]) < WIN) kept.push_back(c);
    end
    exp_q.push_back({kept.size() == 0, 8'hA5, ev});
    foreach (kept[k]) exp_q.push_back({k == kept.size() - 1, 8'(kept[k]), vals[kept[k]*CW +: CW]});
  endtask

  function automatic logic [NT*CW-1:0] rand_vals(input int hit_pct);
    logic [NT*CW-1:0] v;
    for (int c = 0; c < NT; c++) begin
      if (int'($urandom_range(0, 99)) < hit_pct) v[c*CW +: CW] = 8'($urandom_range(0, WIN - 1));
      else v[c*CW +: CW] = 8'($urandom_range(WIN, 255));
    end
    return v;
  endfunction

  task automatic run_event(input logic [NT*CW-1:0] vals, input bit rand_ready, input int extra_trig,
                           input bit trig_at_last, output int clr_cnt, output int gate_cnt,
                           output logic [7:0] drop_snap, output bit timeout);
    int n;
    bit changed;
    timeout  = 1'b0;
    changed  = 1'b0;
    clr_cnt  = 0;
    gate_cnt = 0;
    got_q.delete();
    ev_model = ev_model + 8'd1;
    build_exp(vals, ev_model);
    tube_data = vals;
    out_ready = 1'b1;
    trigger   = 1'b1;
    tick;
    trigger = 1'b0;
    while (tube_clr === 1'b1 && clr_cnt < 100) begin
      clr_cnt++;
      tick;
    end
    while (gate_en === 1'b1 && gate_cnt < 1000) begin
      trigger = (gate_cnt < extra_trig);
      gate_cnt++;
      tick;
    end
    trigger   = 1'b0;
    drop_snap = drop_cnt;
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      if (out_valid === 1'b1 && !changed) begin
        tube_data = $urandom;
        changed   = 1'b1;
      end
      out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      trigger   = trig_at_last && (out_valid === 1'b1) && (out_last === 1'b1) && out_ready;
      tick;
      n++;
    end
    trigger   = 1'b0;
    out_ready = 1'b1;
    if (n >= 3000 || clr_cnt >= 100 || gate_cnt >= 1000) timeout = 1'b1;
  endtask

  task automatic test_reset;
    clr = 1'b1;
    trigger = 1'b0;
    out_ready = 1'b1;
    tube_data = '0;
    tick;
    checks += 7;
    if (tube_clr !== 1'b1)    begin errors++; $display("FAIL reset_tube_clr got %b want 1", tube_clr); end
    if (gate_en !== 1'b0)     begin errors++; $display("FAIL reset_gate_en got %b want 0", gate_en); end
    if (out_valid !== 1'b0)   begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (out_last !== 1'b0)    begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
    if (out_data !== 16'h0)   begin errors++; $display("FAIL reset_out_data got %h want 0000", out_data); end
    if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (drop_cnt !== 8'h0)    begin errors++; $display("FAIL reset_drop_cnt got %h want 00", drop_cnt); end
    clr = 1'b0;
    tick;
    checks++;
    if ({busy, tube_clr} !== 2'b01) begin errors++; $display("FAIL reset_idle busy/tube_clr got %b want 01", {busy, tube_clr}); end
  endtask

  task automatic test_known_event;
    int cc, gc;
    logic [7:0] ds;
    bit to;
    run_event({8'd200, 8'd200, 8'd37, 8'd200}, 1'b0, 0, 1'b0, cc, gc, ds, to);
    checks += 4;
    if (to)        begin errors++; $display("FAIL known_timeout got 1 want 0"); end
    if (cc != CC)  begin errors++; $display("FAIL known_clr_cycles got %0d want %0d", cc, CC); end
    if (gc != WIN) begin errors++; $display("FAIL known_gate_cycles got %0d want %0d", gc, WIN); end
    if (got_q.size() == 0 || got_q[0] !== 17'h0A501) begin
      errors++; $display("FAIL known_header got %h want 0a501", got_q.size() ? got_q[0] : 17'h0);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL known_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL known_word%0d got %h want %h", k, got_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [NT*CW-1:0] vals;
    logic [16:0] held;
    int n;
    vals = rand_vals(100);
    got_q.delete();
    ev_model = ev_model + 8'd1;
    build_exp(vals, ev_model);
    tube_data = vals;
    out_ready = 1'b1;
    trigger   = 1'b1;
    tick;
    trigger = 1'b0;
    n = 0;
    while (got_q.size() < 2 && n < 1000) begin tick; n++; end
    checks++;
    if (n >= 1000) begin errors++; $display("FAIL bp_timeout got %0d words want 2", got_q.size()); end
    tube_data = ~vals;
    out_ready = 1'b0;
    held = {out_last, out_data};
    for (int k = 0; k < 5; k++) begin
      tick;
      checks++;
      if ({out_valid, out_last, out_data} !== {1'b1, held}) begin
        errors++; $display("FAIL bp_hold%0d got %b_%h want 1_%h", k, out_valid, {out_last, out_data}, held);
      end
    end
    out_ready = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin tick; n++; end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL bp_word%0d got %h want %h", k, got_q[k], exp_q[k]); end
    end
    checks++;
    if (stab_err != 0) begin errors++; $display("FAIL bp_stability got %0d changes want 0", stab_err); end
  endtask

  task automatic test_random_events;
    int cc, gc;
    logic [7:0] ds;
    bit to;
    logic [NT*CW-1:0] vals;
    for (int e = 0; e < 6; e++) begin
      vals = (e == 0) ? rand_vals(0) : rand_vals(50);
      run_event(vals, 1'b1, 0, 1'b0, cc, gc, ds, to);
      checks += 3;
      if (to)        begin errors++; $display("FAIL rnd%0d_timeout got 1 want 0", e); end
      if (cc != CC)  begin errors++; $display("FAIL rnd%0d_clr_cycles got %0d want %0d", e, cc, CC); end
      if (gc != WIN) begin errors++; $display("FAIL rnd%0d_gate_cycles got %0d want %0d", e, gc, WIN); end
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", e, got_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
        checks++;
        if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL rnd%0d_word%0d got %h want %h", e, k, got_q[k], exp_q[k]); end
      end
    end
    checks++;
    if (stab_err != 0) begin errors++; $display("FAIL rnd_stability got %0d changes want 0", stab_err); end
  endtask

  task automatic test_drops;
    int cc, gc, drop_model, nwords;
    logic [7:0] ds;
    bit to;
    pulse_clr;
    drop_model = 0;
    run_event(rand_vals(60), 1'b0, 3, 1'b1, cc, gc, ds, to);
    drop_model = 3;
    checks += 2;
    if (to) begin errors++; $display("FAIL drop_a_timeout got 1 want 0"); end
    if (ds !== 8'(drop_model)) begin errors++; $display("FAIL drop_window got %0d want %0d", ds, drop_model); end
    drop_model++;
    checks++;
    if (drop_cnt !== 8'(drop_model)) begin errors++; $display("FAIL drop_last_coincident got %0d want %0d", drop_cnt, drop_model); end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL drop_a_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL drop_a_word%0d got %h want %h", k, got_q[k], exp_q[k]); end
    end
    nwords = got_q.size();
    repeat (3) tick;
    checks++;
    if (busy !== 1'b0 || got_q.size() != nwords) begin
      errors++; $display("FAIL drop_no_restart busy=%b words=%0d want busy=0 words=%0d", busy, got_q.size(), nwords);
    end
    for (int e = 0; e < 2; e++) begin
      run_event(rand_vals(60), e == 0, WIN, 1'b0, cc, gc, ds, to);
      drop_model = (drop_model + WIN > 255) ? 255 : drop_model + WIN;
      checks += 2;
      if (to) begin errors++; $display("FAIL drop_sat%0d_timeout got 1 want 0", e); end
      if (drop_cnt !== 8'(drop_model)) begin errors++; $display("FAIL drop_sat%0d got %0d want %0d", e, drop_cnt, drop_model); end
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL drop_sat%0d_count got %0d want %0d", e, got_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
        checks++;
        if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL drop_sat%0d_word%0d got %h want %h", e, k, got_q[k], exp_q[k]); end
      end
    end
  endtask

  task automatic test_abort;
    int cc, gc, n;
    logic [7:0] ds;
    bit to;
    logic [NT*CW-1:0] vals;
    pulse_clr;
    vals = rand_vals(100);
    got_q.delete();
    tube_data = vals;
    out_ready = 1'b1;
    trigger   = 1'b1;
    tick;
    trigger = 1'b0;
    n = 0;
    while (got_q.size() < 2 && n < 1000) begin tick; n++; end
    checks++;
    if (n >= 1000) begin errors++; $display("FAIL abort_timeout got %0d words want 2", got_q.size()); end
    clr = 1'b1;
    #1;
    checks++;
    if ({tube_clr, gate_en, out_valid, out_last, busy, out_data, drop_cnt} !== {5'b10000, 16'h0, 8'h0}) begin
      errors++;
      $display("FAIL abort_outputs got clr=%b gate=%b v=%b l=%b busy=%b data=%h drop=%h want 1 0 0 0 0 0000 00",
               tube_clr, gate_en, out_valid, out_last, busy, out_data, drop_cnt);
    end
    tick;
    clr = 1'b0;
    ev_model = 8'd0;
    repeat (20) tick;
    checks++;
    if (got_q.size() != 2) begin errors++; $display("FAIL abort_no_more_words got %0d want 2", got_q.size()); end
    run_event(vals, 1'b0, 0, 1'b0, cc, gc, ds, to);
    checks += 2;
    if (to) begin errors++; $display("FAIL abort_next_timeout got 1 want 0"); end
    if (got_q.size() == 0 || got_q[0] !== 17'h0A501) begin
      errors++; $display("FAIL abort_next_header got %h want 0a501", got_q.size() ? got_q[0] : 17'h0);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL abort_next_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL abort_next_word%0d got %h want %h", k, got_q[k], exp_q[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_known_event();
    test_backpressure();
    test_random_events();
    test_drops();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
